qmult_seq: RTL and testbench

//   Sequential sign-magnitude fixed-point multiplier (Q fraction bits, N total, MSB = sign).

---
 rtl/qmult_seq_pkg.sv | 13 +
 rtl/qmult_seq_if.sv | 22 ++
 rtl/qmult_seq.sv | 102 ++++++++++
 tb/tb_qmult_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/qmult_seq_pkg.sv
// Shared fixed-point defaults and FSM encoding for the sign-magnitude arithmetic blocks.
package qmult_seq_pkg;

    localparam int Q_DEF = 23;
    localparam int N_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/qmult_seq_if.sv
// Request/result bundle of the sequential multiplier; master drives operands, slave returns the product.
interface qmult_seq_if #(
    parameter int N = 32
);
    logic         i_start;
    logic [N-1:0] multiplicand;
    logic [N-1:0] multiplier;
    logic [N-1:0] mult_res;
    logic         mult_res_vld;
    logic         busy;
    logic         mult_ovf;

    modport master (
        output i_start, multiplicand, multiplier,
        input  mult_res, mult_res_vld, busy, mult_ovf
    );

    modport slave (
        input  i_start, multiplicand, multiplier,
        output mult_res, mult_res_vld, busy, mult_ovf
    );
endinterface

// File: rtl/qmult_seq.sv
// Sequential sign-magnitude Q-format multiplier: one multiplier magnitude bit per cycle, N cycles per result.
module qmult_seq
    import qmult_seq_pkg::*;
#(
    parameter int Q = Q_DEF,
    parameter int N = N_DEF
) (
    input  logic      clk,
    input  logic      rst,
    qmult_seq_if.slave bus
);
    localparam int MAG_W = N - 1;
    localparam int ACC_W = 2 * MAG_W;
    localparam int CNT_W = $clog2(N);
    localparam logic [MAG_W-1:0] MAG_MAX = '1;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   a_sh;
    logic [MAG_W-1:0]   b_sh;
    logic               sign;
    logic               load, step, finish, last;

    // Select the Q-aligned window of the full product; anything above it saturates.
    function automatic logic [N:0] finalize(input logic [ACC_W-1:0] p, input logic s);
        logic             ovf;
        logic [MAG_W-1:0] mag;
        ovf = (p >> (Q + MAG_W)) != '0;
        mag = ovf ? MAG_MAX : p[Q+MAG_W-1:Q];
        return {ovf, s & (mag != '0), mag};
    endfunction

    assign last     = (cnt == CNT_W'(MAG_W - 1));
    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (load)
                cnt <= '0;
            else if (step)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    load      = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (last)
                    state_nxt = DONE;
            end
            DONE: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift-add: the multiplicand walks left while the multiplier walks right, avoiding a barrel shifter.
    always_ff @(posedge clk) begin
        if (load) begin
            a_sh <= ACC_W'(bus.multiplicand[MAG_W-1:0]);
            b_sh <= bus.multiplier[MAG_W-1:0];
            sign <= bus.multiplicand[N-1] ^ bus.multiplier[N-1];
            acc  <= '0;
        end else if (step) begin
            if (b_sh[0])
                acc <= acc + a_sh;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mult_res     <= '0;
            bus.mult_ovf     <= 1'b0;
            bus.mult_res_vld <= 1'b0;
        end else begin
            bus.mult_res_vld <= finish;
            if (finish)
                {bus.mult_ovf, bus.mult_res} <= finalize(acc, sign);
        end
    end

endmodule

// File: tb/tb_qmult_seq.sv
// Directed bench for qmult_seq with a scoreboard of expected products.
module tb_qmult_seq;
    localparam int Q = 23;
    localparam int N = 32;

    typedef struct packed {
        logic [N-1:0] res;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qmult_seq_if #(.N(N)) bus();
    qmult_seq #(.Q(Q), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-3:0] p;
        logic [N-2:0]   mag;
        exp_t           e;
        p     = (2*N-2)'(a[N-2:0]) * (2*N-2)'(b[N-2:0]);
        e.ovf = (p >> (Q + N - 1)) != 0;
        mag   = e.ovf ? {(N-1){1'b1}} : p[Q+N-2:Q];
        e.res = {(mag != 0) & (a[N-1] ^ b[N-1]), mag};
        return e;
    endfunction

    function automatic logic [N-1:0] sm_add(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N-1:0] mx, my, m;
        logic         s;
        mx = {1'b0, x[N-2:0]};
        my = {1'b0, y[N-2:0]};
        if (x[N-1] == y[N-1]) begin m = mx + my; s = x[N-1]; end
        else if (mx >= my)    begin m = mx - my; s = x[N-1]; end
        else                  begin m = my - mx; s = y[N-1]; end
        return {s & (m[N-2:0] != 0), m[N-2:0]};
    endfunction

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [N-1:0] a, input logic [N-1:0] b, input bit push);
        bus.i_start      = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        if (push) sb.push_back(model(a, b));
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic wait_vld(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.mult_res_vld && n < limit);
        if (!bus.mult_res_vld) n = -1;
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        check({tag, "_sb"}, N'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_res"}, bus.mult_res, e.res);
            check({tag, "_ovf"}, N'(bus.mult_ovf), N'(e.ovf));
        end
    endtask

    task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
        int n;
        logic [N-1:0] held;
        start(a, b, 1'b1);
        check({tag, "_busy"}, N'(bus.busy), 1);
        wait_vld(100, n);
        check({tag, "_lat"}, N'(n), 32);
        check({tag, "_busy_vld"}, N'(bus.busy), 0);
        pop_check(tag);
        held = bus.mult_res;
        tick();
        check({tag, "_vld_pulse"}, N'(bus.mult_res_vld), 0);
        check({tag, "_hold"}, bus.mult_res, held);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, vld_seen;
        logic [N-1:0] r1, r2, ra, rb;

        bus.i_start      = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_res",  bus.mult_res, 0);
        check("rst_vld",  N'(bus.mult_res_vld), 0);
        check("rst_busy", N'(bus.busy), 0);
        check("rst_ovf",  N'(bus.mult_ovf), 0);
        rst = 1'b0;
        tick();

        run_op("p15xp2", 32'h00C0_0000, 32'h0100_0000);
        check("p15xp2_val", bus.mult_res, 32'h0180_0000);
        run_op("n15xp2", 32'h80C0_0000, 32'h0100_0000);
        check("n15xp2_val", bus.mult_res, 32'h8180_0000);
        run_op("n15xn2", 32'h80C0_0000, 32'h8100_0000);
        check("n15xn2_val", bus.mult_res, 32'h0180_0000);
        run_op("zero_sign", 32'h0000_0000, 32'h80C0_0000);
        check("zero_sign_val", bus.mult_res, 32'h0000_0000);
        run_op("trunc_zero", 32'h0000_0001, 32'h8040_0000);
        check("trunc_zero_val", bus.mult_res, 32'h0000_0000);
        run_op("negzero_op", 32'h8000_0000, 32'h0100_0000);
        check("negzero_op_val", bus.mult_res, 32'h0000_0000);
        for (int i = 0; i < 4; i++) begin
            ra = $urandom();
            rb = {$urandom_range(1, 0), 8'h00, 23'($urandom())};
            run_op($sformatf("rand%0d", i), ra, rb);
        end

        // One operation with a second start 5 cycles in, then a start in the valid cycle.
        start(32'h00C0_0000, 32'h0100_0000, 1'b1);
        repeat (4) tick();
        start(32'h0800_0000, 32'h0800_0000, 1'b0);
        wait_vld(100, n);
        check("ignore_lat", N'(n + 5), 32);
        pop_check("ignore");
        check("ignore_val", bus.mult_res, 32'h0180_0000);
        r1 = bus.mult_res;
        start(32'h80C0_0000, 32'h0100_0000, 1'b1);
        wait_vld(100, n);
        check("b2b_gap", N'(n + 1), 33);
        pop_check("b2b");
        r2 = bus.mult_res;
        check("chain_sum", sm_add(r1, r2), 32'h0000_0000);

        run_op("ovf_pos", 32'h0800_0000, 32'h0800_0000);
        check("ovf_pos_val", bus.mult_res, 32'h7FFF_FFFF);
        run_op("ovf_neg", 32'h8800_0000, 32'h0800_0000);
        check("ovf_neg_val", bus.mult_res, 32'hFFFF_FFFF);
        check("ovf_neg_flag", N'(bus.mult_ovf), 1);

        // Abort mid-calculation with an asynchronous reset pulse.
        start(32'h00C0_0000, 32'h0100_0000, 1'b0);
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        check("abort_res",  bus.mult_res, 0);
        check("abort_ovf",  N'(bus.mult_ovf), 0);
        check("abort_busy", N'(bus.busy), 0);
        check("abort_vld",  N'(bus.mult_res_vld), 0);
        tick();
        rst = 1'b0;
        vld_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.mult_res_vld) vld_seen++;
        end
        check("abort_no_vld", N'(vld_seen), 0);
        run_op("after_abort", 32'h00C0_0000, 32'h0100_0000);
        check("after_abort_val", bus.mult_res, 32'h0180_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
